// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite command sequencer: response codes,
// sequencer states and the default-width command record.
package axi4_lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } seq_state_t;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/axi4_lite_cmd_fifo.sv
// Small command FIFO with a combinational head view so the sequencer can
// latch the head on the same edge that moves it into ISSUE.
module axi4_lite_cmd_fifo
    import axi4_lite_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = $bits(cmd_t),
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    // Admission looks only at the registered count, so a pop in the same
    // cycle never lets a push into a full FIFO.
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/axi4_lite_cmd_sequencer.sv
// Buffers read/write commands and issues them one at a time to axi4_lite_top,
// returning one response per command with timeout protection.
module axi4_lite_cmd_sequencer
    import axi4_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRESS    = 32,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDRESS-1:0]       cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    output logic                     read_s,
    output logic                     write_s,
    output logic [ADDRESS-1:0]       address,
    output logic [DATA_WIDTH-1:0]    W_data,
    input  logic                     mon_rvalid,
    input  logic                     mon_rready,
    input  logic [DATA_WIDTH-1:0]    mon_rdata,
    input  logic [1:0]               mon_rresp,
    input  logic                     mon_bvalid,
    input  logic                     mon_bready,
    input  logic [1:0]               mon_bresp,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [1:0]               rsp_resp,
    output logic                     rsp_timeout,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    // Same field layout as cmd_t, sized by this instance's parameters.
    typedef struct packed {
        logic                  write;
        logic [ADDRESS-1:0]    addr;
        logic [DATA_WIDTH-1:0] wdata;
    } seq_cmd_t;

    seq_cmd_t              push_cmd;
    seq_cmd_t              head_cmd;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;

    seq_state_t            state_reg;
    logic [TMO_W-1:0]      tmo_cnt_reg;
    logic                  cur_write_reg;
    logic                  read_s_reg;
    logic                  write_s_reg;
    logic [ADDRESS-1:0]    address_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  rsp_valid_reg;
    logic                  rsp_write_reg;
    logic [DATA_WIDTH-1:0] rsp_rdata_reg;
    logic [1:0]            rsp_resp_reg;
    logic                  rsp_timeout_reg;
    logic                  wr_done;
    logic                  rd_done;

    assign push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    assign fifo_pop = (state_reg == ISSUE);

    axi4_lite_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(seq_cmd_t))
    ) u_cmd_fifo (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .push      (cmd_valid),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .head_data (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Only the handshake matching the in-flight direction completes it.
    assign wr_done = cur_write_reg && mon_bvalid && mon_bready;
    assign rd_done = !cur_write_reg && mon_rvalid && mon_rready;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg       <= IDLE;
            tmo_cnt_reg     <= '0;
            cur_write_reg   <= 1'b0;
            read_s_reg      <= 1'b0;
            write_s_reg     <= 1'b0;
            address_reg     <= '0;
            wdata_reg       <= '0;
            rsp_valid_reg   <= 1'b0;
            rsp_write_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_resp_reg    <= OKAY;
            rsp_timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        address_reg   <= head_cmd.addr;
                        wdata_reg     <= head_cmd.wdata;
                        cur_write_reg <= head_cmd.write;
                        read_s_reg    <= !head_cmd.write;
                        write_s_reg   <= head_cmd.write;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    read_s_reg  <= 1'b0;
                    write_s_reg <= 1'b0;
                    tmo_cnt_reg <= '0;
                    state_reg   <= WAIT;
                end
                WAIT: begin
                    // A completion on the last permitted cycle beats the timeout.
                    if (wr_done || rd_done) begin
                        rsp_valid_reg   <= 1'b1;
                        rsp_write_reg   <= cur_write_reg;
                        rsp_rdata_reg   <= wr_done ? '0 : mon_rdata;
                        rsp_resp_reg    <= wr_done ? mon_bresp : mon_rresp;
                        rsp_timeout_reg <= 1'b0;
                        state_reg       <= RESP;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        rsp_valid_reg   <= 1'b1;
                        rsp_write_reg   <= cur_write_reg;
                        rsp_rdata_reg   <= '0;
                        rsp_resp_reg    <= SLVERR;
                        rsp_timeout_reg <= 1'b1;
                        state_reg       <= RESP;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cmd_ready   = !fifo_full;
    assign read_s      = read_s_reg;
    assign write_s     = write_s_reg;
    assign address     = address_reg;
    assign W_data      = wdata_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_write   = rsp_write_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_resp    = rsp_resp_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign busy        = (state_reg != IDLE);

endmodule
